// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch PC owner and prefetch queue feeding decode
// Optional IFQ_BYPASS_EN: an ack into an empty queue drives the outputs combinationally.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [AW-1:0]            redirect_pc,
    output logic                     imem_req,
    output logic [AW-1:0]            imem_addr,
    input  logic                     imem_ack,
    input  logic [DW-1:0]            imem_rdata,
    output logic [DW-1:0]            inst_out,
    output logic [AW-1:0]            inst_pc,
    output logic                     inst_valid,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [DW-1:0] data_q [DEPTH];
    logic [AW-1:0] pc_q   [DEPTH];
    logic [AW-1:0] fetch_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          discard;

    logic xfer;
    logic accept;
    logic head_valid;
    logic push;
    logic pop;

    assign xfer       = imem_req && imem_ack;
    // A response is kept only if no redirect has superseded the request.
    assign accept     = xfer && !discard && !redirect;
    assign head_valid = (count != '0);
    assign pop        = head_valid && !stall && !redirect;
    assign q_count    = count;

`ifdef IFQ_BYPASS_EN
    logic bypass;
    assign bypass     = accept && !head_valid;
    assign push       = accept && !(bypass && !stall);
    assign inst_valid = head_valid || bypass;
    assign inst_out   = head_valid ? data_q[rd_ptr] : (bypass ? imem_rdata : '0);
    assign inst_pc    = head_valid ? pc_q[rd_ptr]   : (bypass ? fetch_pc   : '0);
`else
    assign push       = accept;
    assign inst_valid = head_valid;
    assign inst_out   = head_valid ? data_q[rd_ptr] : '0;
    assign inst_pc    = head_valid ? pc_q[rd_ptr]   : '0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]   <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc  <= '0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            discard   <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            // Request stays stable until acked; a fresh one issues the following cycle.
            if (xfer) begin
                imem_req <= 1'b0;
            end else if (!imem_req && !redirect && count < FULL_CNT) begin
                imem_req  <= 1'b1;
                imem_addr <= fetch_pc;
            end

            if (redirect) begin
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= redirect_pc;
                discard  <= imem_req && !imem_ack;
            end else begin
                if (xfer)
                    discard <= 1'b0;
                if (accept)
                    fetch_pc <= fetch_pc + AW'(1);
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (PW+1)'(1);
                    2'b01:   count <= count - (PW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - scoreboard bench for inst_fetch_queue with a transaction-level model
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] inst_out;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic [2:0]  q_count;

    inst_fetch_queue #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_out(inst_out),
        .inst_pc(inst_pc), .inst_valid(inst_valid), .q_count(q_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    bit          model_on = 1'b0;
    int          mcount = 0;
    logic [15:0] mpc = '0;
    bit          mdisc = 1'b0;
    bit          hold_prev = 1'b0;
    logic [15:0] prev_addr = '0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected behaviour derived from the transaction rules: which acked words survive,
    // what address each kept request must carry, and how many words are buffered.
    task automatic model_eval();
        bit xfer;
        bit pop;
        bit push;
        xfer = imem_req && imem_ack;
        chk(int'(q_count) == mcount, "q_count", int'(q_count), mcount);
        chk(inst_valid == (mcount != 0), "inst_valid", int'(inst_valid), int'(mcount != 0));
        if (!inst_valid)
            chk(inst_out == 16'h0 && inst_pc == 16'h0, "bubble", {inst_pc, inst_out}, 0);
        if (hold_prev)
            chk(imem_req && imem_addr == prev_addr, "req_hold", {15'h0, imem_req, imem_addr},
                {16'h1, prev_addr});
        hold_prev = imem_req && !imem_ack;
        prev_addr = imem_addr;
        pop  = (mcount != 0) && !stall && !redirect;
        push = 1'b0;
        if (xfer && !mdisc)
            chk(imem_addr == mpc, "imem_addr", int'(imem_addr), int'(mpc));
        if (redirect) begin
            mcount = 0;
            exp_q.delete();
            mpc   = redirect_pc;
            mdisc = imem_req && !imem_ack;
        end else begin
            if (xfer) begin
                if (!mdisc) begin
                    push = 1'b1;
                    if (mcount >= DEPTH)
                        chk(1'b0, "overflow", mcount, DEPTH - 1);
                    exp_q.push_back({mpc, 16'hA000 + mpc});
                    mpc = mpc + 16'h1;
                end
                mdisc = 1'b0;
            end
            mcount = mcount + int'(push) - int'(pop);
        end
    endtask

    task automatic step(input bit st, input bit rd, input logic [15:0] rpc, input bit ack);
        @(negedge clk);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = ack;
        imem_rdata  = 16'hA000 + imem_addr;
        #2;
        if (model_on)
            model_eval();
    endtask

    // Monitor: every pop of a valid head must match the oldest surviving word.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (model_on && inst_valid && !stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_word", {inst_pc, inst_out}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(inst_pc == e[31:16], "inst_pc", int'(inst_pc), int'(e[31:16]));
                    chk(inst_out == e[15:0], "inst_out", int'(inst_out), int'(e[15:0]));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1);
            chk(!imem_req && !inst_valid && inst_out == 0 && q_count == 0, "reset_state",
                {imem_req, inst_valid, q_count, inst_out}, 0);
        end
        rst = 1'b1;
        model_on = 1'b1;

        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, 16'h0, 1'b1);
        chk(q_count == 3'd4, "fill_count", int'(q_count), 4);
        chk(!imem_req, "fill_no_req", int'(imem_req), 0);

        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 16'h0, 1'b1);

        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, imem_req, 16'h0040, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b0, 16'h0, 1'b1);

        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 16'h0, 1'b1);
        step(1'b1, 1'b1, 16'h0100, imem_req);
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, 16'h0, 1'b1);

        step(1'b0, 1'b1, 16'hFFFF, 1'b1);
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b0, 16'h0, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            logic [15:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, rpc, $urandom_range(0, 2) != 0);
        end

        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, 16'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
